// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory between instruction fetch (IF) and
// the load/store stage (DM). One transaction is in flight at a time. DM has
// fixed priority, but IF is granted after STARVE_MAX consecutive DM grants
// that it had to wait through. Read data returns on per-requester strobes.

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_INIT     = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE      = LAT_W'(1);
    localparam logic [SC_W-1:0]  STARVE_LIMIT = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0]  SC_ONE       = SC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner_dm;
    logic [LAT_W-1:0]  lat_cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic              dm_win;
    logic              if_win;
    logic              last_beat;

    // IF overrides DM only once it has watched STARVE_MAX DM grants go by
    assign dm_win    = dm_req && !(if_req && (starve_cnt == STARVE_LIMIT));
    assign if_win    = if_req && !dm_win;
    assign last_beat = (state == WAIT) && (lat_cnt == LAT_ONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the one-cycle grant and memory strobes of ISSUE
    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        mem_en     = 1'b0;
        case (state)
            IDLE: begin
                if (if_win || dm_win) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                dm_gnt     = owner_dm;
                if_gnt     = !owner_dm;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAT_ONE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arbitration bookkeeping, registered memory payload and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_dm   <= 1'b0;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_win) begin
                        owner_dm  <= 1'b1;
                        mem_addr  <= dm_addr;
                        mem_we    <= dm_we;
                        mem_wdata <= dm_wdata;
                        if (if_req) begin
                            starve_cnt <= starve_cnt + SC_ONE;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (if_win) begin
                        owner_dm   <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_we     <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - LAT_ONE;
                end
                default: begin
                    lat_cnt <= '0;
                end
            endcase
        end
    end

    // Capture returning read data for the owner and pulse its rvalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if (last_beat) begin
                if (owner_dm) begin
                    dm_rvalid <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory of the mini MIPS core between the instruction-fetch requester (IF) and the data-memory requester (DM, load/store stage). Only one memory transaction is in flight at a time. DM has fixed priority, with a bounded-starvation guarantee for IF. Read data is returned through per-requester response strobes. The block sits between the core's fetch and memory stages and the memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid; must be ≥1
- STARVE_MAX, 4, maximum consecutive DM grants while IF is pending; must be ≥1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  IF read request; sampled only in IDLE
- if_addr  in  ADDR_W  IF read address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  DATA_W  IF read data; holds until the next IF read completes
- dm_req  in  1  DM request; sampled only in IDLE
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_gnt  out  1  one-cycle pulse: DM request accepted
- dm_rvalid  out  1  one-cycle pulse: DM read data valid, or write complete
- dm_rdata  out  DATA_W  DM read data; unchanged by writes
- mem_en  out  1  one-cycle memory access strobe
- mem_we  out  1  write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en`

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If any request is pending, arbitrate, latch the winner, and register its payload into the `mem_*` outputs. Go to ISSUE.
- **Arbitration**
  - DM wins unless `if_req`=1 and `starve_cnt`==STARVE_MAX; in that case IF wins.
  - `starve_cnt` increments on a DM win while `if_req`=1.
  - `starve_cnt` clears to 0 on an IF win, or on a DM win with `if_req`=0.
- **ISSUE** (exactly one cycle)
  - `mem_en`=1, and the winner's `gnt`=1.
  - Load `lat_cnt`=MEM_LAT and go to WAIT.
- **WAIT**
  - Decrement `lat_cnt` each cycle.
  - In the cycle `lat_cnt`==1: capture `mem_rdata` into the owner's rdata register (reads only) and assert the owner's `rvalid` on the next edge. Go to IDLE.
- `mem_addr`, `mem_we` and `mem_wdata` hold their values from ISSUE until the next ISSUE. `mem_we` is meaningful only while `mem_en`=1.
- **Requester rules**
  - A requester holds `req` and its payload stable until it sees `gnt`. Values after `gnt` are ignored until the arbiter is back in IDLE.
  - `req` high in the `rvalid` cycle is treated as a new request.
- **Reset** (`rst`=0, asynchronous, any state)
  - State goes to IDLE; all outputs, rdata registers, `starve_cnt` and `lat_cnt` go to 0.
  - An in-flight transaction is abandoned: no `rvalid` is produced and the late `mem_rdata` is ignored.

## Timing
- Requests sampled in IDLE cycle t.
  - Cycle t+1: `gnt` and `mem_en`.
  - Cycle t+1+MEM_LAT: `mem_rdata` valid.
  - Cycle t+2+MEM_LAT: `rvalid`, with rdata valid; arbiter is in IDLE and samples new requests.
- Back-to-back issue period is MEM_LAT+2 cycles.
- `gnt`, `rvalid` and `mem_en` are never high for more than one consecutive cycle.
- At most one of `if_gnt`/`dm_gnt` is high in any cycle; likewise `if_rvalid`/`dm_rvalid`.

## Test plan
- **IF read** (MEM_LAT=2): `if_req`=1 with `if_addr`=0x40, and the memory model returns 0x20080005.
  - Requires `if_gnt` and `mem_en` with `mem_addr`=0x40 at t+1.
  - Requires `if_rvalid`=1 with `if_rdata`=0x20080005 at t+4.
- **DM write**: `dm_we`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF.
  - Requires `mem_en`=1, `mem_we`=1 and `mem_wdata`=0xDEADBEEF at t+1.
  - Requires `dm_rvalid` at t+4 with `dm_rdata` unchanged from its prior value.
- **Starvation bound** (STARVE_MAX=2): `if_req` and `dm_req` held high continuously.
  - Required grant order: DM, DM, IF, DM, DM, IF.
  - Grant spacing is 4 cycles.
- **Simultaneous requests with `starve_cnt`=0**: DM is granted, IF waits.
  - IF is granted exactly 4 cycles after `dm_gnt`, provided `dm_req` then drops.
- **Reset mid-WAIT**: `rst`=0 one cycle after `mem_en`, released 2 cycles later.
  - Requires all outputs = 0 immediately.
  - Requires no `rvalid` afterwards; the next request is serviced normally from IDLE.
- **Idle hold**: both `req`=0 for 10 cycles → `mem_en`, `gnt` and `rvalid` stay 0, and rdata registers are unchanged.
